wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Two-controller to one-peripheral Wishbone B4 (pipelined) arbiter.
- Lets the SPI-bridged Wishbone controller share the peripheral bus with a second controller, such as a future UART bridge or an on-chip DMA.
- Round-robin grant per bus cycle (CYC envelope). Grant is registered; the datapath is a combinational mux steered by that grant.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 8, data width; SEL_W = DATA_W/8
- TIMEOUT, 255, watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  Wishbone clock
- rst  in  1  synchronous reset, active-high
- cN_cyc  in  1  controller N cycle request (N=0,1; each cN_* line exists for both)
- cN_stb  in  1  controller N strobe
- cN_we  in  1  controller N write enable
- cN_adr  in  ADDR_W  controller N address
- cN_dat_w  in  DATA_W  controller N write data
- cN_sel  in  SEL_W  controller N byte select
- cN_dat_r  out  DATA_W  read data to controller N
- cN_ack  out  1  acknowledge to controller N
- cN_stall  out  1  stall to controller N
- p_cyc, p_stb, p_we  out  1  to peripheral
- p_adr  out  ADDR_W  to peripheral
- p_dat_w  out  DATA_W  to peripheral
- p_sel  out  SEL_W  to peripheral
- p_dat_r  in  DATA_W  from peripheral
- p_ack, p_stall  in  1  from peripheral
- grant  out  2  one-hot current owner, 00 = idle (debug)

Behaviour:
- Decided: one clock clk; reset rst synchronous, active-high.
- State register: IDLE, OWN0, OWN1. Also a last-owner bit `last`.
- Reset: state=IDLE, last=1 so c0 wins the first tie. All outputs go low except cN_stall=1; grant=00. Reset mid-transaction drops the grant immediately, with no ack completion.
- IDLE:
  - Only c0_cyc high -> OWN0 next cycle. Only c1_cyc high -> OWN1.
  - Both high -> the controller != last.
  - Grant latency is 1 clk from cyc rising.
- OWNn:
  - Held while cn_cyc=1; no preemption.
  - On the cycle cn_cyc is seen low: if the other controller's cyc=1, go directly to OWN(other); else go to IDLE.
  - last updates to n when OWNn is left.
- Mux while OWNn:
  - p_cyc/stb/we/adr/dat_w/sel = cn_* inputs.
  - cn_ack = p_ack; cn_stall = p_stall; cn_dat_r = p_dat_r.
- Non-owner: ack=0, stall=1, dat_r=0. In IDLE: p_cyc=p_stb=0 and other p_* outputs 0.
- The cycle the owner drops cyc, p_cyc=0 through the mux. The peripheral therefore sees at least one cycle with cyc=0 between owners.
- A late p_ack arriving after the owner drops cyc is discarded (not routed to either controller). Controllers must not drop cyc with transfers outstanding.
- No internal buffering. Throughput equals the peripheral's once granted.

Optional Feature:
- Macro: WB_ARBITER_TIMEOUT_EN
- With it:
  - Adds ports cN_err out 1.
  - Adds a watchdog counter, $clog2(TIMEOUT+1) bits. It clears on grant change and on any p_ack, and increments while the owner's cyc=1.
  - Reaching TIMEOUT: pulse cn_err for 1 clk, force p_cyc=0 for that cycle, set last=n. Next state is OWN(other) if its cyc=1, else IDLE.
  - The owner's cyc stays ignored until it drops and reasserts.
- Without it: no err ports, no counter; an owner may hold the bus indefinitely.

Decomposition:
- Shared package pWishbone:
  - owner_t enum (IDLE, OWN0, OWN1)
  - ADDR_W/DATA_W defaults
  - TIMEOUT default
- One sub-module is natural: wb_arbiter_mux, a purely combinational request/response steering given owner_t. State and watchdog stay in the top.

Test Plan:
- c0_cyc=1 alone, one read of adr 0x0010 with peripheral returning 0xA5 -> grant=01 next clk; c0_dat_r=0xA5 with c0_ack=1; c1_stall=1 throughout.
- Both cyc rise together after reset -> grant=01 first. After c0 drops cyc, grant=10 the next clk with no idle cycle; the following tie goes to c0.
- c1 holds cyc across 4 pipelined writes (0x11..0x14) with p_stall=1 on the 2nd -> peripheral sees exactly 4 accepted stb. c0 stays stalled and gets no ack.
- rst asserted mid-transfer while OWN1 -> next clk grant=00, p_cyc=0, both stalls=1; c0 wins the next tie.
- Stray p_ack while IDLE -> c0_ack=c1_ack=0.
- With WB_ARBITER_TIMEOUT_EN and TIMEOUT=8, c0 granted and the peripheral never acks -> c0_err pulses at the 8th cycle; p_cyc=0 that cycle; pending c1 is granted next clk.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the two-controller Wishbone B4 pipelined arbiter.
package wb_arbiter_pkg;

   // Encoding doubles as the one-hot grant seen on the debug output.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } owner_t;

   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 8;
   localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone B4 pipelined link; "master" drives the request side, "slave" answers it.
// The err line exists only when WB_ARBITER_TIMEOUT_EN is defined.
interface wb_arbiter_if
   import wb_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   localparam int SEL_W = DATA_W / 8;

   // A transfer is accepted on a clock edge where cyc & stb & !stall; each
   // accepted transfer is answered by exactly one ack cycle carrying dat_r.
   logic              cyc;
   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] dat_w;
   logic [SEL_W-1:0]  sel;
   logic [DATA_W-1:0] dat_r;
   logic              ack;
   logic              stall;
`ifdef WB_ARBITER_TIMEOUT_EN
   logic              err;
`endif

   modport master (
      output cyc, stb, we, adr, dat_w, sel,
`ifdef WB_ARBITER_TIMEOUT_EN
      input  err,
`endif
      input  dat_r, ack, stall
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
`ifdef WB_ARBITER_TIMEOUT_EN
      output err,
`endif
      output dat_r, ack, stall
   );

endinterface

// File: rtl/wb_arbiter_mux.sv
// Purely combinational steering of requests and responses toward the routed owner.
// A non-owner sees stall=1, ack=0, dat_r=0; IDLE parks the peripheral side at zero.
module wb_arbiter_mux
   import wb_arbiter_pkg::*;
(
   input  owner_t        i_route,
   wb_arbiter_if.slave   c0,
   wb_arbiter_if.slave   c1,
   wb_arbiter_if.master  p
);

   logic w_sel0;
   logic w_sel1;

   assign w_sel0 = (i_route == OWN0);
   assign w_sel1 = (i_route == OWN1);

   assign p.cyc   = w_sel0 ? c0.cyc   : (w_sel1 ? c1.cyc   : 1'b0);
   assign p.stb   = w_sel0 ? c0.stb   : (w_sel1 ? c1.stb   : 1'b0);
   assign p.we    = w_sel0 ? c0.we    : (w_sel1 ? c1.we    : 1'b0);
   assign p.adr   = w_sel0 ? c0.adr   : (w_sel1 ? c1.adr   : '0);
   assign p.dat_w = w_sel0 ? c0.dat_w : (w_sel1 ? c1.dat_w : '0);
   assign p.sel   = w_sel0 ? c0.sel   : (w_sel1 ? c1.sel   : '0);

   assign c0.ack   = w_sel0 & p.ack;
   assign c0.stall = w_sel0 ? p.stall : 1'b1;
   assign c0.dat_r = w_sel0 ? p.dat_r : '0;

   assign c1.ack   = w_sel1 & p.ack;
   assign c1.stall = w_sel1 ? p.stall : 1'b1;
   assign c1.dat_r = w_sel1 ? p.dat_r : '0;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter: two Wishbone controllers share one peripheral, granted per CYC envelope.
// Optional watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   wb_arbiter_if.slave   c0,
   wb_arbiter_if.slave   c1,
   wb_arbiter_if.master  p,
   output logic [1:0]    grant
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("wb_arbiter: TIMEOUT must be at least 1");
   end

   owner_t r_state;
   owner_t w_next;
   owner_t w_route;
   logic   r_last;
   logic   w_last_nx;
   logic   w_req0;
   logic   w_req1;
   logic   w_fire;

`ifdef WB_ARBITER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] r_wdog;
   logic            r_ign0;
   logic            r_ign1;
   logic            w_own_cyc;

   // A timed-out controller stays ignored until it drops cyc at least once.
   assign w_req0    = c0.cyc & ~r_ign0;
   assign w_req1    = c1.cyc & ~r_ign1;
   assign w_own_cyc = ((r_state == OWN0) & c0.cyc) | ((r_state == OWN1) & c1.cyc);
   assign w_fire    = w_own_cyc & (r_wdog == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || (w_next != r_state) || p.ack) begin
         r_wdog <= '0;
      end else if (w_own_cyc) begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ign0 <= 1'b0;
         r_ign1 <= 1'b0;
      end else begin
         r_ign0 <= (w_fire && r_state == OWN0) ? 1'b1 : (r_ign0 & c0.cyc);
         r_ign1 <= (w_fire && r_state == OWN1) ? 1'b1 : (r_ign1 & c1.cyc);
      end
   end

   assign c0.err = w_fire & (r_state == OWN0);
   assign c1.err = w_fire & (r_state == OWN1);
`else
   assign w_req0 = c0.cyc;
   assign w_req1 = c1.cyc;
   assign w_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_next;
         r_last  <= w_last_nx;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_last_nx = r_last;
      case (r_state)
         IDLE: begin
            if (w_req0 && (!w_req1 || r_last)) begin
               w_next = OWN0;
            end else if (w_req1) begin
               w_next = OWN1;
            end
         end
         OWN0: begin
            if (!w_req0 || w_fire) begin
               w_last_nx = 1'b0;
               w_next    = w_req1 ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (!w_req1 || w_fire) begin
               w_last_nx = 1'b1;
               w_next    = w_req0 ? OWN0 : IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Route only while the owner still holds cyc, so a late ack reaches nobody.
   always_comb begin
      w_route = IDLE;
      if (!w_fire) begin
         if (r_state == OWN0 && c0.cyc) begin
            w_route = OWN0;
         end else if (r_state == OWN1 && c1.cyc) begin
            w_route = OWN1;
         end
      end
   end

   assign grant = r_state;

   wb_arbiter_mux u_mux (
      .i_route (w_route),
      .c0      (c0),
      .c1      (c1),
      .p       (p)
   );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; define WB_ARBITER_TIMEOUT_EN to also exercise the watchdog.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   logic       clk;
   logic       rst;
   logic [1:0] grant;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] exp_q[$];

   wb_arbiter_if #(.ADDR_W(16), .DATA_W(8)) c0_if ();
   wb_arbiter_if #(.ADDR_W(16), .DATA_W(8)) c1_if ();
   wb_arbiter_if #(.ADDR_W(16), .DATA_W(8)) p_if ();

`ifdef WB_ARBITER_TIMEOUT_EN
   wb_arbiter #(.TIMEOUT(8)) dut (
`else
   wb_arbiter dut (
`endif
      .clk   (clk),
      .rst   (rst),
      .c0    (c0_if),
      .c1    (c1_if),
      .p     (p_if),
      .grant (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      c0_if.cyc = 0; c0_if.stb = 0; c0_if.we = 0; c0_if.adr = '0; c0_if.dat_w = '0; c0_if.sel = '0;
      c1_if.cyc = 0; c1_if.stb = 0; c1_if.we = 0; c1_if.adr = '0; c1_if.dat_w = '0; c1_if.sel = '0;
      p_if.dat_r = '0; p_if.ack = 0; p_if.stall = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int idx;
      int accepted;
      logic stall_done;
      logic prev_acc;

      rst = 1'b1;
      idle_inputs();
      tick();
      tick();

      // reset state
      check("rst_grant", grant, 2'b00);
      check("rst_p_cyc", p_if.cyc, 1'b0);
      check("rst_p_stb", p_if.stb, 1'b0);
      check("rst_c0_stall", c0_if.stall, 1'b1);
      check("rst_c1_stall", c1_if.stall, 1'b1);
      check("rst_c0_ack", c0_if.ack, 1'b0);
      rst = 1'b0;
      tick();

      // single read by c0
      c0_if.cyc = 1; c0_if.stb = 1; c0_if.we = 0; c0_if.adr = 16'h0010; c0_if.sel = 1'b1;
      settle();
      check("t1_grant_latency", grant, 2'b00);
      check("t1_p_cyc_pre", p_if.cyc, 1'b0);
      tick();
      check("t1_grant", grant, 2'b01);
      check("t1_p_cyc", p_if.cyc, 1'b1);
      check("t1_p_adr", p_if.adr, 16'h0010);
      check("t1_p_we", p_if.we, 1'b0);
      check("t1_c1_stall", c1_if.stall, 1'b1);
      tick();
      c0_if.stb = 0; p_if.ack = 1; p_if.dat_r = 8'hA5;
      settle();
      check("t1_c0_ack", c0_if.ack, 1'b1);
      check("t1_c0_dat_r", c0_if.dat_r, 8'hA5);
      check("t1_c1_ack", c1_if.ack, 1'b0);
      check("t1_c1_stall2", c1_if.stall, 1'b1);
      tick();
      p_if.ack = 0; p_if.dat_r = '0; c0_if.cyc = 0;
      settle();
      check("t1_drop_p_cyc", p_if.cyc, 1'b0);
      tick();
      check("t1_idle", grant, 2'b00);

      // tie after reset goes to c0, then direct handover to c1
      do_reset();
      c0_if.cyc = 1; c1_if.cyc = 1;
      tick();
      check("t2_tie_c0", grant, 2'b01);
      c0_if.cyc = 0;
      settle();
      check("t2_gap_p_cyc", p_if.cyc, 1'b0);
      tick();
      check("t2_handover", grant, 2'b10);
      check("t2_p_cyc_c1", p_if.cyc, 1'b1);
      c1_if.cyc = 0;
      tick();
      check("t2_idle", grant, 2'b00);
      c0_if.cyc = 1; c1_if.cyc = 1;
      tick();
      check("t2_next_tie_c0", grant, 2'b01);
      c0_if.cyc = 0; c1_if.cyc = 0;
      tick();

      // c1 pipelined writes with one stall; c0 waits
      c1_if.cyc = 1;
      tick();
      check("t3_grant", grant, 2'b10);
      c0_if.cyc = 1;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h11 + 8'(i));
      idx = 0; accepted = 0; stall_done = 0; prev_acc = 0;
      for (int k = 0; k < 10 && idx < 4; k++) begin
         c1_if.stb = 1; c1_if.we = 1; c1_if.sel = 1'b1;
         c1_if.adr = 16'h0020 + 16'(idx);
         c1_if.dat_w = 8'h11 + 8'(idx);
         p_if.stall = (idx == 1) && !stall_done;
         p_if.ack = prev_acc;
         settle();
         check("t3_c0_stall", c0_if.stall, 1'b1);
         check("t3_c0_ack", c0_if.ack, 1'b0);
         check("t3_c1_stall_fwd", c1_if.stall, p_if.stall);
         prev_acc = 0;
         if (p_if.cyc && p_if.stb && !p_if.stall) begin
            accepted++;
            prev_acc = 1;
            if (exp_q.size() == 0) check("t3_extra_stb", 1'b1, 1'b0);
            else check("t3_wr_data", p_if.dat_w, exp_q.pop_front());
         end
         if (p_if.stall) stall_done = 1;
         if (!c1_if.stall) idx++;
         tick();
      end
      c1_if.stb = 0; p_if.stall = 0; p_if.ack = prev_acc;
      settle();
      check("t3_last_ack", c1_if.ack, 1'b1);
      check("t3_c0_ack_end", c0_if.ack, 1'b0);
      check("t3_stb_count", accepted, 4);
      check("t3_queue_empty", exp_q.size(), 0);
      tick();
      p_if.ack = 0; c1_if.cyc = 0; c1_if.we = 0;
      settle();
      check("t3_drop_p_cyc", p_if.cyc, 1'b0);
      tick();
      check("t3_c0_next", grant, 2'b01);
      c0_if.cyc = 0;
      tick();

      // reset while c1 owns the bus
      c1_if.cyc = 1; c1_if.stb = 1;
      tick();
      check("t4_own1", grant, 2'b10);
      rst = 1'b1;
      tick();
      check("t4_grant", grant, 2'b00);
      check("t4_p_cyc", p_if.cyc, 1'b0);
      check("t4_c0_stall", c0_if.stall, 1'b1);
      check("t4_c1_stall", c1_if.stall, 1'b1);
      rst = 1'b0; c1_if.stb = 0; c0_if.cyc = 1; c1_if.cyc = 1;
      tick();
      check("t4_tie_c0", grant, 2'b01);
      c0_if.cyc = 0; c1_if.cyc = 0;
      tick();
      tick();

      // stray ack while idle
      p_if.ack = 1; p_if.dat_r = 8'hFF;
      settle();
      check("t5_grant", grant, 2'b00);
      check("t5_c0_ack", c0_if.ack, 1'b0);
      check("t5_c1_ack", c1_if.ack, 1'b0);
      check("t5_c0_dat_r", c0_if.dat_r, 8'h00);
      p_if.ack = 0; p_if.dat_r = '0;
      tick();

`ifdef WB_ARBITER_TIMEOUT_EN
      // watchdog: c0 never acked, c1 pending
      do_reset();
      c0_if.cyc = 1; c0_if.stb = 1;
      tick();
      check("t6_grant0", grant, 2'b01);
      c1_if.cyc = 1;
      for (int k = 1; k < 8; k++) begin
         settle();
         check("t6_no_err", c0_if.err, 1'b0);
         tick();
      end
      settle();
      check("t6_err_pulse", c0_if.err, 1'b1);
      check("t6_p_cyc_forced", p_if.cyc, 1'b0);
      tick();
      check("t6_err_clear", c0_if.err, 1'b0);
      check("t6_grant1", grant, 2'b10);
      c1_if.cyc = 0;
      tick();
      tick();
      check("t6_c0_ignored", grant, 2'b00);
      c0_if.cyc = 0;
      tick();
      c0_if.cyc = 1;
      tick();
      check("t6_c0_regrant", grant, 2'b01);
      c0_if.cyc = 0; c0_if.stb = 0;
      tick();
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
